// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch
// requester (read-only) and the data requester (read/write, byte-enabled).
// Data wins by default. A saturating starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants taken while fetch was waiting.
// Only one transaction is in flight at a time, and at least one IDLE cycle
// separates consecutive transactions.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read/i_addr            fetch request (level, held until i_resp)
//   i_rdata/i_resp           fetch read data / completion pulse
//   d_read/d_write/d_addr    data request (level, held until d_resp)
//   d_wdata/d_byte_enable    data write payload
//   d_rdata/d_resp           data read data / completion pulse
//   pmem_*                   physical memory port
//   busy                     transaction in flight
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_enable,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_addr,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                d_req;

  // State and grant registers; strobes come straight from these.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Arbitration, grant capture and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    d_req   = d_read | d_write;

    case (state_q)
      IDLE: begin
        // Fetch wins only when alone or once data has starved it long enough.
        if (i_read && (!d_req || (cnt_q >= LIMIT))) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          wdata_d = '0;
          be_d    = '1;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end else if (d_req) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_byte_enable;
          // Simultaneous read and write is treated as a write.
          rd_d    = ~d_write;
          wr_d    = d_write;
          if (i_read) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign pmem_read        = rd_q;
  assign pmem_write       = wr_q;
  assign pmem_addr        = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;

  // Completion is returned in the same cycle as pmem_resp.
  assign i_resp  = (state_q == SERVE_I) && pmem_resp;
  assign d_resp  = (state_q == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_byte_enable = '0;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_byte_enable;
  logic [DW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference: who owns the port (0 none, 1 fetch, 2 data),
  // the transaction it was granted, and how many data grants fetch has waited.
  int            who = 0;
  int            starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be = '0;
  bit            m_rd = 1'b0;
  bit            m_wr = 1'b0;
  bit            seen_i = 1'b0;
  bit            seen_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already set; check, advance the model, clock.
  task automatic step();
    bit ir, dr;
    #1;
    ir = (who == 1) && pmem_resp;
    dr = (who == 2) && pmem_resp;
    check("busy", 32'(busy), 32'(who != 0));
    check("pmem_read", 32'(pmem_read), 32'(who != 0 && m_rd));
    check("pmem_write", 32'(pmem_write), 32'(who != 0 && m_wr));
    if (who != 0) begin
      check("pmem_addr", 32'(pmem_addr), 32'(m_addr));
      check("pmem_wdata", 32'(pmem_wdata), 32'(m_wdata));
      check("pmem_be", 32'(pmem_byte_enable), 32'(m_be));
    end
    check("i_resp", 32'(i_resp), 32'(ir));
    check("d_resp", 32'(d_resp), 32'(dr));
    if (ir) check("i_rdata", 32'(i_rdata), 32'(pmem_rdata));
    if (dr) check("d_rdata", 32'(d_rdata), 32'(pmem_rdata));
    seen_i = ir;
    seen_d = dr;

    if (rst) begin
      who = 0; starve = 0; m_rd = 0; m_wr = 0;
    end else if (who == 0) begin
      if (i_read && (!(d_read || d_write) || starve >= LIMIT)) begin
        who = 1; m_addr = i_addr; m_wdata = '0; m_be = '1;
        m_rd = 1; m_wr = 0; starve = 0;
      end else if (d_read || d_write) begin
        who = 2; m_addr = d_addr; m_wdata = d_wdata; m_be = d_byte_enable;
        m_wr = d_write; m_rd = !d_write;
        starve = i_read ? ((starve < 15) ? starve + 1 : 15) : 0;
      end
    end else if (pmem_resp) begin
      who = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int nd, ni;
    bit after_i_is_d, got_i;
    logic [1:0] r;

    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset values of the whole memory port.
    check("rst_addr", 32'(pmem_addr), 32'h0);
    check("rst_wdata", 32'(pmem_wdata), 32'h0);
    check("rst_be", 32'(pmem_byte_enable), 32'h0);
    step();
    rst = 1'b0;

    // Single fetch with a three-cycle memory.
    i_read = 1; i_addr = 16'h0040;
    step();
    i_addr = 16'h7777;
    step(); step();
    pmem_resp = 1; pmem_rdata = 16'h1234;
    #1 check("t1_i_rdata", 32'(i_rdata), 32'h1234);
    step();
    i_read = 0; pmem_resp = 0;
    step();

    // Single data write with partial byte enable.
    d_write = 1; d_addr = 16'h3000; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    step(); step();
    pmem_resp = 1;
    step();
    d_write = 0; pmem_resp = 0;
    step();

    // Starvation: both held, memory answers at once.
    i_read = 1; d_read = 1; pmem_resp = 1;
    nd = 0; ni = 0; got_i = 0; after_i_is_d = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (seen_i) begin ni++; got_i = 1; end
      else if (seen_d) begin
        if (got_i && ni == 1 && !after_i_is_d) after_i_is_d = 1;
        if (!got_i) nd++;
      end
    end
    check("starve_d_before_i", 32'(nd), 32'(LIMIT));
    check("starve_d_after_i", 32'(after_i_is_d), 32'h1);
    i_read = 0; d_read = 0; pmem_resp = 0;
    step(); step();

    // Reset during a data write, then a late memory response.
    d_write = 1; d_addr = 16'h3000; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
    step(); step();
    rst = 1; d_write = 0;
    step();
    rst = 0;
    step();
    pmem_resp = 1;
    step();
    pmem_resp = 0;
    step();

    // Read+write together and an address change mid-service.
    d_read = 1; d_write = 1; d_addr = 16'h0123; d_wdata = 16'h5A5A; d_byte_enable = 2'b11;
    step();
    d_addr = 16'hFFFF;
    step(); step();
    pmem_resp = 1;
    step();
    d_read = 0; d_write = 0; pmem_resp = 0;
    step();

    // Randomized traffic with occasional reset and stray memory responses.
    for (int k = 0; k < 4000; k++) begin
      if (!i_read || seen_i) i_read = ($urandom_range(0, 2) == 0);
      i_addr = AW'($urandom);
      if (!(d_read || d_write) || seen_d) begin
        r = 2'($urandom_range(0, 3));
        d_read = r[0]; d_write = r[1];
      end
      d_addr = AW'($urandom);
      d_wdata = DW'($urandom);
      d_byte_enable = BW'($urandom);
      pmem_rdata = DW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      pmem_resp = !rst && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
